// File: rtl/slot_ctrl_if.sv
// Player/reel bus of the slot machine sequencer.
// Controller side is the slave modport; stimulus/panel side is master.
interface slot_ctrl_if;
    logic       coin;
    logic       btn_start;
    logic       btn_stop;
    logic [2:0] pic0;
    logic [2:0] pic1;
    logic [2:0] pic2;
    logic [2:0] reel_btn;
    logic [7:0] credit;
    logic [1:0] win;
    logic       busy;

    modport master (
        output coin, btn_start, btn_stop, pic0, pic1, pic2,
        input  reel_btn, credit, win, busy
    );

    modport slave (
        input  coin, btn_start, btn_stop, pic0, pic1, pic2,
        output reel_btn, credit, win, busy
    );
endinterface

// File: rtl/slot_ctrl.sv
// Three-reel slot game sequencer: credits, reel start/stop, scoring, payout.
// Optional SLOT_AUTO_STOP_EN adds a timed automatic stop per reel.
module slot_ctrl #(
    parameter int MIN_SPIN      = 16,
    parameter int AUTO_STOP_CYC = 1000,
    parameter int PAY_PAIR      = 2,
    parameter int PAY_TRIPLE    = 10,
    parameter int CREDIT_MAX    = 99
) (
    input logic        clk,
    input logic        clr,
    slot_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        SPIN0,
        SPIN1,
        SPIN2,
        SETTLE,
        PAY
    } state_t;

    localparam int DW = $clog2(MIN_SPIN + AUTO_STOP_CYC + 2);
    localparam logic [DW-1:0] DWELL_MAX = '1;
    localparam logic [DW-1:0] MIN_D = DW'(MIN_SPIN);

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    reel_q, reel_d;
    logic [7:0]    credit_q, credit_d;
    logic [1:0]    win_q, win_d;
    logic          busy_q, busy_d;

    logic       spinning;
    logic       stop_ok;
    logic       auto_stop;
    logic       stop_acc;
    logic       start_acc;
    logic       triple;
    logic       pair;
    logic [7:0] pay;
    logic [9:0] sum;

    assign spinning = (state_q == SPIN0) || (state_q == SPIN1) ||
                      (state_q == SPIN2);
    assign stop_ok  = spinning && (dwell_q >= MIN_D);

`ifdef SLOT_AUTO_STOP_EN
    localparam logic [DW-1:0] AUTO_D = DW'(MIN_SPIN + AUTO_STOP_CYC);
    assign auto_stop = spinning && (dwell_q >= AUTO_D);
`else
    assign auto_stop = 1'b0;
`endif

    // A manual press coinciding with the auto stop is still one stop.
    assign stop_acc  = stop_ok && (bus.btn_stop || auto_stop);
    assign start_acc = (state_q == IDLE) && bus.btn_start &&
                       (credit_q != 8'd0);

    always_comb begin
        triple = (bus.pic0 == bus.pic1) && (bus.pic1 == bus.pic2);
        pair   = !triple && ((bus.pic0 == bus.pic1) ||
                             (bus.pic1 == bus.pic2) ||
                             (bus.pic0 == bus.pic2));
        pay = 8'd0;
        if (state_q == PAY) begin
            unique case (1'b1)
                triple:  pay = 8'(PAY_TRIPLE);
                pair:    pay = 8'(PAY_PAIR);
                default: pay = 8'd0;
            endcase
        end
    end

    // Start debit only happens with credit >= 1, so no underflow here.
    always_comb begin
        sum = 10'(credit_q) + 10'(bus.coin) + 10'(pay) - 10'(start_acc);
        if (sum > 10'(CREDIT_MAX)) begin
            credit_d = 8'(CREDIT_MAX);
        end else begin
            credit_d = sum[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        reel_d  = reel_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = SPIN0;
                    reel_d  = 3'b000;
                    win_d   = 2'b00;
                end
            end
            SPIN0: begin
                if (stop_acc) begin
                    state_d   = SPIN1;
                    reel_d[0] = 1'b1;
                end
            end
            SPIN1: begin
                if (stop_acc) begin
                    state_d   = SPIN2;
                    reel_d[1] = 1'b1;
                end
            end
            SPIN2: begin
                if (stop_acc) begin
                    state_d   = SETTLE;
                    reel_d[2] = 1'b1;
                end
            end
            SETTLE: state_d = PAY;
            PAY: begin
                state_d = IDLE;
                win_d   = {triple, pair};
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (spinning && (dwell_q != DWELL_MAX)) begin
            dwell_d = dwell_q + 1'b1;
        end else begin
            dwell_d = dwell_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            dwell_q  <= '0;
            reel_q   <= 3'b111;
            credit_q <= 8'd0;
            win_q    <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            reel_q   <= reel_d;
            credit_q <= credit_d;
            win_q    <= win_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.reel_btn = reel_q;
    assign bus.credit   = credit_q;
    assign bus.win      = win_q;
    assign bus.busy     = busy_q;
endmodule
